// File: rtl/bendlab_iic_pkg.sv
// bendlab_iic_pkg: shared constants and FSM state type for the bend-sensor I2C slave model
package bendlab_iic_pkg;
  localparam logic [6:0] SLAVE_ADDR_DEF = 7'h12;
  localparam int REG_SAMPLE_HI = 0;
  localparam int REG_SAMPLE_LO = 1;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_e;
endpackage

// File: rtl/iic_bus_sync.sv
// iic_bus_sync: SCL/SDA synchroniser producing SCL edge and START/STOP pulses
module iic_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_STAGES:0] scl_q, scl_d, sda_q, sda_d;
  logic scl_s, scl_p, sda_p;
  always_comb begin
    scl_d = {scl_q[SYNC_STAGES-1:0], scl_i};
    sda_d = {sda_q[SYNC_STAGES-1:0], sda_i};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end
  assign scl_s     = scl_q[SYNC_STAGES-1];
  assign sda_s     = sda_q[SYNC_STAGES-1];
  assign scl_p     = scl_q[SYNC_STAGES];
  assign sda_p     = sda_q[SYNC_STAGES];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
endmodule

// File: rtl/bendlab_iic_slave_model.sv
// bendlab_iic_slave_model: I2C slave emulating the bend-sensor register map
module bendlab_iic_slave_model
  import bendlab_iic_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = SLAVE_ADDR_DEF,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic [15:0]   sample_i,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, rd_b, wr_data_q, wr_data_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_n, wr_addr_q, wr_addr_d;
  logic sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic sda_s, scl_rise, scl_fall, start_det, stop_det;
  iic_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_s(sda_s),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det), .stop_det(stop_det)
  );
  assign ptr_n = ptr_q + PW'(1);
  assign rd_b  = ptr_q == PW'(REG_SAMPLE_HI) ? sample_i[15:8] :
                 ptr_q == PW'(REG_SAMPLE_LO) ? sample_i[7:0] : regs_q[ptr_q];
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          sh_d  = {sh_q[6:0], sda_s};
          cnt_d = cnt_q + 4'd1;
        end
        WDATA_ACK: begin
          if (|ptr_q[PW-1:1]) begin
            regs_d[ptr_q] = sh_q;
            wr_strobe_d   = 1'b1;
            wr_addr_d     = ptr_q;
            wr_data_d     = sh_q;
          end
          ptr_d = ptr_n;
        end
        RDATA: cnt_d = cnt_q + 4'd1;
        RACK: begin
          if (sda_s) begin
            state_d = IGNORE;
            busy_d  = 1'b0;
          end else begin
            ptr_d   = ptr_n;
            sh_d    = regs_q[ptr_n];
            cnt_d   = '0;
            state_d = RDATA;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ADDR: begin
          if (cnt_q == 4'd8) begin
            state_d  = sh_q[7:1] == SLAVE_ADDR ? ADDR_ACK : IGNORE;
            sda_oe_d = sh_q[7:1] == SLAVE_ADDR;
            busy_d   = sh_q[7:1] == SLAVE_ADDR;
          end
        end
        ADDR_ACK: begin
          cnt_d = '0;
          if (sh_q[0]) begin
            regs_d[REG_SAMPLE_HI] = sample_i[15:8];
            regs_d[REG_SAMPLE_LO] = sample_i[7:0];
            sh_d     = {rd_b[6:0], 1'b0};
            sda_oe_d = ~rd_b[7];
            state_d  = RDATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = PTR;
          end
        end
        PTR: begin
          if (cnt_q == 4'd8) begin
            ptr_d    = sh_q[PW-1:0];
            sda_oe_d = 1'b1;
            state_d  = PTR_ACK;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          sda_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = WDATA;
        end
        WDATA: begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = WDATA_ACK;
          end
        end
        RDATA: begin
          sda_oe_d = cnt_q == 4'd8 ? 1'b0 : ~sh_q[7];
          sh_d     = cnt_q == 4'd8 ? sh_q : {sh_q[6:0], 1'b0};
          state_d  = cnt_q == 4'd8 ? RACK : RDATA;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      regs_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
endmodule
